apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Sits between the CPU data-memory port and the APB peripheral bus, directly upstream of the APB RAM and other APB slaves.
- Latches one CPU load/store request at a time and decodes the address to a one-hot PSEL.
- Runs the APB SETUP/ACCESS protocol and stalls on PREADY.
- Returns read data and a completion strobe to the CPU.

Parameters:
- NUM_SLV, 4, number of APB slave slots (1..16); slot i occupies 4 KiB.
- BASE_HI, 16'h1000, required value of addr[31:16] for any mapped slot.
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  APB/system clock, rising edge.
- PRESET  in  1  reset, asynchronous, active-low.
- transfer  in  1  CPU request strobe.
- write  in  1  1 = store, 0 = load.
- addr  in  32  CPU byte address.
- wdata  in  32  store data.
- rdata  out  32  load data, valid when ready=1.
- ready  out  1  transfer-complete strobe.
- err  out  1  unmapped address (or timeout), valid when ready=1.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB access phase.
- PWDATA  out  32  APB write data.
- PSEL  out  NUM_SLV  one-hot slave select.
- PRDATA  in  32 x NUM_SLV  per-slave read data (unpacked array).
- PREADY  in  NUM_SLV  per-slave ready.

Behaviour:
- Reset (PRESET=0, asynchronous):
  - state=IDLE.
  - PADDR, PWDATA, PWRITE = 0; PSEL=0; PENABLE=0.
  - ready=0, err=0, rdata=0.
  - Reset mid-transfer abandons the transfer without any completion strobe.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - transfer=1 latches addr, wdata, write into PADDR/PWDATA/PWRITE and the decoded slot.
  - Next state SETUP. transfer=0 stays IDLE.
- SETUP (exactly 1 cycle): PSEL[slot]=1 if mapped, PENABLE=0; next state ACCESS.
- ACCESS:
  - PSEL held, PENABLE=1. Selected PREADY=0 holds ACCESS with all APB outputs stable.
  - Selected PREADY=1 gives the completion cycle: ready=1, rdata=PRDATA[slot] for loads (0 for stores), err=0.
  - After completion: transfer=1 in the same cycle latches the new request and goes to SETUP (back-to-back, PSEL stays high); transfer=0 goes to IDLE.
- transfer is ignored in SETUP and in non-completing ACCESS cycles. The CPU holds addr/wdata/write only in the cycle transfer=1.
- ready is a single-cycle pulse. rdata and err are combinational in the completion cycle and 0 otherwise.
- Decode: mapped iff addr[31:16]==BASE_HI and addr[15:12] < NUM_SLV; slot = addr[15:12].
- Unmapped address:
  - SETUP/ACCESS still run with PSEL all zero.
  - The first ACCESS cycle completes with ready=1, err=1, rdata=0. No slave sees the transfer.
- Latency: transfer in cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2. A zero-wait slave gives ready in cycle 2; each PREADY wait cycle adds 1.
- PADDR carries the full 32-bit CPU address unmodified; slaves do their own word indexing.
- PREADY of unselected slots is ignored.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to ACCESS and increments each ACCESS cycle with selected PREADY=0.
  - When the count reaches TIMEOUT_CYCLES, the transfer completes: ready=1, err=1, rdata=32'hDEAD_BEEF, PSEL/PENABLE drop.
  - The FSM then follows normal completion rules.
- Undefined: no counter; ACCESS waits indefinitely; err is asserted only for unmapped addresses.

Decomposition:
- Package apb_pkg holds:
  - typedef enum logic [1:0] apb_state_t {IDLE, SETUP, ACCESS};
  - localparam APB_SLOT_W=4;
  - localparam APB_BASE_HI=16'h1000;
  - localparam APB_TIMEOUT_RDATA=32'hDEAD_BEEF.
- Sub-module apb_addr_decoder (combinational):
  - Inputs: addr. Outputs: one-hot sel[NUM_SLV], hit.
  - Instantiated once, fed from the latched PADDR.

Test Plan:
- Reset: PRESET low mid-ACCESS → next sample shows PSEL=0, PENABLE=0, ready=0, PADDR=0; no ready pulse follows.
- Store then load, zero-wait RAM at slot 0:
  - transfer, write=1, addr=32'h1000_0010, wdata=32'hCAFE_0001 → SETUP cycle 1, ACCESS cycle 2 with PSEL=4'b0001, PWRITE=1, ready in cycle 2.
  - Load from the same address → rdata=32'hCAFE_0001, err=0.
- Wait states: slot 2 (addr=32'h1000_2004) holds PREADY=0 for 3 cycles → PADDR/PWDATA/PSEL/PENABLE stable; ready first in cycle 5.
- Back-to-back: transfer asserted in the completion cycle with addr=32'h1000_1000 → next cycle is SETUP with PSEL=4'b0010, no IDLE gap.
- Unmapped: addr=32'h2000_0000 and addr=32'h1000_7000 (NUM_SLV=4) → PSEL=0 throughout; ready=1, err=1, rdata=0 in cycle 2.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4: slave never asserts PREADY → ready=1, err=1, rdata=32'hDEAD_BEEF after 4 wait cycles; FSM returns to IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the CPU-to-APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  localparam int          APB_SLOT_W        = 4;
  localparam logic [15:0] APB_BASE_HI       = 16'h1000;
  localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: maps addr[15:12] to a one-hot slave select
// when the upper half-word matches the peripheral window.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV = 4,
  parameter logic [15:0] BASE_HI = APB_BASE_HI
) (
  input  logic [31:0]        addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               hit
);

  logic [APB_SLOT_W-1:0] slot;
  logic [11:0]           unused_offset;

  assign slot          = addr[15:12];
  assign unused_offset = addr[11:0];

  // Slot indices at or above NUM_SLV fall outside the populated window.
  assign hit = (addr[31:16] == BASE_HI) && ({1'b0, slot} < 5'(NUM_SLV));

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
      assign sel[gi] = hit && (slot == APB_SLOT_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// CPU load/store to APB master bridge: one outstanding request, SETUP/ACCESS
// sequencing, PREADY stalls. Optional ACCESS wait limit under APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLV        = 4,
  parameter logic [15:0] BASE_HI        = APB_BASE_HI,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               transfer,
  input  logic               write,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               err,
  output logic [31:0]        PADDR,
  output logic               PWRITE,
  output logic               PENABLE,
  output logic [31:0]        PWDATA,
  output logic [NUM_SLV-1:0] PSEL,
  input  logic [31:0]        PRDATA [NUM_SLV],
  input  logic [NUM_SLV-1:0] PREADY
);

  apb_state_t          state_reg, state_next;
  logic [31:0]         paddr_reg, pwdata_reg;
  logic                pwrite_reg;
  logic                load_req;
  logic                complete;
  logic                timeout_fire;
  logic                slv_ready;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_hit;
  logic [31:0]         prdata_masked [NUM_SLV];
  logic [31:0]         prdata_sel;

  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV),
    .BASE_HI (BASE_HI)
  ) u_dec (
    .addr (paddr_reg),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // Unmapped transfers have no slave to wait on and complete immediately.
  assign slv_ready = dec_hit ? |(PREADY & dec_sel) : 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_rd_mask
      assign prdata_masked[gi] = PRDATA[gi] & {32{dec_sel[gi]}};
    end
  endgenerate

  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      prdata_sel = prdata_sel | prdata_masked[i];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt_reg;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wait_cnt_reg <= '0;
    end else if (state_reg != ACCESS) begin
      wait_cnt_reg <= '0;
    end else if (!slv_ready && (wait_cnt_reg != CNT_LIMIT)) begin
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end
  end

  assign timeout_fire = (state_reg == ACCESS) && !slv_ready && (wait_cnt_reg == CNT_LIMIT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_fire       = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    load_req   = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (transfer) begin
          load_req   = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (slv_ready || timeout_fire) begin
          complete = 1'b1;
          // A request offered in the completion cycle chains straight into SETUP.
          if (transfer) begin
            load_req   = 1'b1;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    ready   = complete;
    err     = 1'b0;
    rdata   = '0;
    PSEL    = '0;
    PENABLE = 1'b0;
    if ((state_reg != IDLE) && !timeout_fire) begin
      PSEL = dec_sel;
    end
    if ((state_reg == ACCESS) && !timeout_fire) begin
      PENABLE = 1'b1;
    end
    if (complete) begin
      if (timeout_fire) begin
        err   = 1'b1;
        rdata = APB_TIMEOUT_RDATA;
      end else if (!dec_hit) begin
        err = 1'b1;
      end else if (!pwrite_reg) begin
        rdata = prdata_sel;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_reg  <= IDLE;
      paddr_reg  <= '0;
      pwdata_reg <= '0;
      pwrite_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_req) begin
        paddr_reg  <= addr;
        pwdata_reg <= wdata;
        pwrite_reg <= write;
      end
    end
  end

  assign PADDR  = paddr_reg;
  assign PWDATA = pwdata_reg;
  assign PWRITE = pwrite_reg;

endmodule
